// File: rtl/ncl_sync_sink.sv
// Clocked sink for a dual-rail NCL pipeline: synchronizes and filters wavefronts, returns ZCOMP, buffers DATA words in a FIFO.
// Optional token counter and stall output are enabled by defining NCL_SYNC_SINK_CNT_EN.
module ncl_sync_sink #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int STABLE = 1
) (
  input  logic                     clk,
  input  logic                     init_n,
  input  logic [WIDTH-1:0]         rail0,
  input  logic [WIDTH-1:0]         rail1,
  output logic                     zcomp,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err,
`ifdef NCL_SYNC_SINK_CNT_EN
  output logic [15:0]              tok_cnt,
  output logic                     stall,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic { W_DATA, W_NULL } state_e;
  typedef enum logic [1:0] { DEC_PART, DEC_NULL, DEC_DATA, DEC_ILL } dec_e;

  // Reset asserts immediately with init_n but releases two clocks later, aligned to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [WIDTH-1:0] r0_s0_q, r0_s1_q, r1_s0_q, r1_s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_s0_q <= '0;
      r0_s1_q <= '0;
      r1_s0_q <= '0;
      r1_s1_q <= '0;
    end else begin
      r0_s0_q <= rail0;
      r0_s1_q <= r0_s0_q;
      r1_s0_q <= rail1;
      r1_s1_q <= r1_s0_q;
    end
  end

  dec_e dec;

  always_comb begin
    dec = DEC_PART;
    if (|(r0_s1_q & r1_s1_q))       dec = DEC_ILL;
    else if (&(r0_s1_q ^ r1_s1_q))  dec = DEC_DATA;
    else if (~|(r0_s1_q | r1_s1_q)) dec = DEC_NULL;
  end

  // run_d counts consecutive edges (including this one) the decode has been seen; saturates at STABLE+1.
  dec_e       dec_q;
  logic [2:0] run_q, run_d;
  logic       stable;

  always_comb begin
    run_d = 3'd1;
    if (dec == dec_q) begin
      if (run_q >= 3'(STABLE + 1)) run_d = run_q;
      else                         run_d = run_q + 3'd1;
    end
  end

  assign stable = (run_d >= 3'(STABLE + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= DEC_PART;
      run_q <= '0;
    end else begin
      dec_q <= dec;
      run_q <= run_d;
    end
  end

  state_e           state_q;
  logic             zcomp_q, err_q, out_valid_q;
  logic [LW-1:0]    level_q, level_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             data_ok, full, rd, wr;

  assign data_ok = stable && (dec == DEC_DATA);
  assign full    = (level_q == LW'(DEPTH));
  assign rd      = out_valid_q && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign wr      = (state_q == W_DATA) && data_ok && (!full || rd);

  always_comb begin
    level_d = level_q;
    case ({wr, rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q     <= level_d;
      out_valid_q <= (level_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= r1_s1_q;
  end

`ifdef NCL_SYNC_SINK_CNT_EN
  logic [15:0] tok_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= W_DATA;
      zcomp_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef NCL_SYNC_SINK_CNT_EN
      tok_cnt_q <= '0;
`endif
    end else begin
      if (stable && dec == DEC_ILL) err_q <= 1'b1;
      case (state_q)
        W_DATA: begin
          if (wr) begin
            state_q <= W_NULL;
            zcomp_q <= 1'b1;
`ifdef NCL_SYNC_SINK_CNT_EN
            tok_cnt_q <= tok_cnt_q + 16'd1;
`endif
          end
        end
        W_NULL: begin
          if (stable && dec == DEC_NULL) begin
            state_q <= W_DATA;
            zcomp_q <= 1'b0;
          end
        end
        default: begin
          state_q <= W_DATA;
          zcomp_q <= 1'b0;
        end
      endcase
    end
  end

  assign zcomp     = zcomp_q;
  assign err       = err_q;
  assign level     = level_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? mem_q[rd_ptr_q] : '0;

`ifdef NCL_SYNC_SINK_CNT_EN
  assign tok_cnt = tok_cnt_q;
  assign stall   = (state_q == W_DATA) && data_ok && full;
`endif

endmodule
